io_input_port: RTL and testbench
================================

# io_input_port

Debounced, synchronized input-port block that carries the board switches and DIP switches into the CPU. It conditions raw `sw_pin` and `dip_pin` levels into stable 32-bit `in_port` words. It also raises a sticky "new value" status that the CPU clears through a read strobe. It sits between the pins and the `sc_computer_main` input ports, and complements the output path that drives LEDs and digitrons.

## Interface
- `WIDTH`, default 5: number of raw input bits.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range ≥ 2.
- `clk` input, 1 bit: single system clock (100 MHz); all state on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `raw_in` input, `WIDTH` bits: asynchronous pin levels.
- `rd_en` input, 1 bit: one-cycle CPU read strobe for the status word.
- `in_port` output, 32 bits: `{(32-WIDTH)'b0, stable}`.
- `status` output, 32 bits: `{30'b0, overrun, pending}`.
- `irq` output, 1 bit: present only with `IO_INPUT_IRQ_EN`.

## Operation
- **Synchronizer.** Each bit passes through a two-flop synchronizer: `raw_in` → `s1` → `s2`.
- **Debounce.** There is one counter `cnt` for the whole vector, `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - `s2 == stable`: `cnt` ← 0.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s2`, `cnt` ← 0, and `chg` pulses for one cycle.
  - Any bit flip in `s2` while counting does not restart the count. The value accepted is `s2` at the accepting edge.
  - Any `s2` episode that differs from `stable` for fewer than `DEBOUNCE_CYCLES` consecutive cycles is discarded.
- **Status bits.**
  - `pending` sets on `chg` and clears on `rd_en`.
  - `overrun` sets on `chg` while `pending` is already 1, and clears on `rd_en`.
- **Simultaneous `chg` and `rd_en`:**
  - `pending` = 1.
  - `overrun` = 0. The read consumes the old notification, and the new change is pending.
- **Writes.** `in_port` is read-only. `rd_en` has no effect on `stable` or `cnt`.
- **Reset.** Reset has priority over all other activity in the same cycle. It returns every register to its reset value:
  - `s1`, `s2`, `stable`, `cnt` ← 0.
  - `pending`, `overrun`, `irq` ← 0.
  - `in_port` = 0 and `status` = 0 immediately after the reset edge.
  - Reset in the middle of a debounce discards the partial count.
  - If any switch is high at reset release, it is accepted after the normal latency and sets `pending`.

## Timing
- Edge E0 is the first edge that samples a new `raw_in` value.
  - `s2` shows the new value after E1.
  - `in_port` updates after edge E(`DEBOUNCE_CYCLES`+1), which is `DEBOUNCE_CYCLES`+2 edges total.
  - `pending` sets on that same edge.
- `status` reflects `rd_en` one edge later.
- The outputs are registers with no combinational path from inputs.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1`. There is no wrap-around.

## Configuration
- Macro: `IO_INPUT_IRQ_EN`.
- **Defined:**
  - The `irq` port exists. It is a registered level equal to `pending`.
  - It asserts on the same edge as `pending` and deasserts one edge after `rd_en`. Under the simultaneous `chg` + `rd_en` case it stays high.
- **Undefined:**
  - The `irq` port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package `io_pkg`:
  - `IO_PORT_W` = 32.
  - `DEBOUNCE_DEFAULT` = 1_000_000.
  - Status bit indices `ST_PENDING` = 0 and `ST_OVERRUN` = 1.
- One sub-module: `sync2`, a parameterized-width two-flop synchronizer with synchronous active-high reset.
- The debounce counter, the `stable` register and the status logic stay in `io_input_port`.

## Test plan
All scenarios use `WIDTH`=5 and `DEBOUNCE_CYCLES`=4.
- **Clean change:** reset, then `raw_in` 5'b00000 → 5'b10101 held.
  - `in_port` = 0x00000015 and `status` = 0x1 exactly 6 edges after the first sampling edge.
  - `status` = 0x0 one edge after `rd_en`.
- **Glitch rejection:** `raw_in` pulses 5'b00001 for 3 cycles, then returns to 0.
  - `in_port` stays 0 and `status` stays 0.
  - A 4-cycle `s2` episode is accepted.
- **Overrun:** accept 0x03, do not read, then accept 0x07.
  - `in_port` = 0x7 and `status` = 0x3.
  - `rd_en` → `status` = 0x0.
- **Simultaneous event:** assert `rd_en` on the accepting edge of a change while `pending`=1.
  - `status` = 0x1 (`pending` kept, `overrun` cleared).
- **Reset mid-debounce:** `raw_in` = 5'b11111, assert `reset` 2 cycles after the change, hold it 1 cycle.
  - All outputs are 0 after the reset edge.
  - `in_port` = 0x1F after a full 6-edge latency measured from reset release.
- **IRQ** (with `IO_INPUT_IRQ_EN`): `irq` rises on the same edge as `pending` and falls one edge after `rd_en`.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the board input/output port blocks.
// Status word layout and debounce defaults live here so CPU-side code and RTL agree.
package io_pkg;

  localparam int IO_PORT_W        = 32;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  localparam int ST_PENDING = 0;
  localparam int ST_OVERRUN = 1;

  function automatic logic [IO_PORT_W-1:0] pack_status(input logic pending,
                                                       input logic overrun);
    logic [IO_PORT_W-1:0] word;
    word             = '0;
    word[ST_PENDING] = pending;
    word[ST_OVERRUN] = overrun;
    return word;
  endfunction

endpackage

// File: rtl/io_input_port_if.sv
// Pin/CPU-side bundle of the input port; the irq wire exists only when
// IO_INPUT_IRQ_EN is defined.
interface io_input_port_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0]             raw_in;
    logic                         rd_en;
    logic [io_pkg::IO_PORT_W-1:0] in_port;
    logic [io_pkg::IO_PORT_W-1:0] status;
`ifdef IO_INPUT_IRQ_EN
    logic                         irq;

    modport master (output raw_in, output rd_en, input in_port, input status, input irq);
    modport slave  (input raw_in, input rd_en, output in_port, output status, output irq);
`else
    modport master (output raw_in, output rd_en, input in_port, input status);
    modport slave  (input raw_in, input rd_en, output in_port, output status);
`endif
endinterface

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous pin levels,
// with synchronous active-high reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1;

    // NOTE: non-blocking assignments make s1 and q update together, giving two real flop stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/io_input_port.sv
// Synchronized, debounced switch input port with a sticky new-value status.
// Define IO_INPUT_IRQ_EN to add a registered irq level that mirrors pending.
module io_input_port
    import io_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    io_input_port_if.slave  bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [CNT_W-1:0] cnt;
    logic             chg;
    logic             pending, pending_nxt;
    logic             overrun, overrun_nxt;

    sync2 #(.WIDTH(WIDTH)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (s2)
    );

    // One counter for the whole vector: bit flips mid-count do not restart it.
    assign chg = (s2 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt    <= '0;
        end else if (chg) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    always_comb begin
        pending_nxt = pending;
        overrun_nxt = overrun;
        if (bus.rd_en) begin
            pending_nxt = 1'b0;
            overrun_nxt = 1'b0;
        end
        // A read coinciding with a change consumes the old notice only.
        if (chg) begin
            pending_nxt = 1'b1;
            overrun_nxt = pending && !bus.rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    assign bus.in_port = {{(IO_PORT_W-WIDTH){1'b0}}, stable};
    assign bus.status  = pack_status(pending, overrun);

`ifdef IO_INPUT_IRQ_EN
    logic irq_r;

    always_ff @(posedge clk) begin
        if (reset) irq_r <= 1'b0;
        else       irq_r <= pending_nxt;
    end

    assign bus.irq = irq_r;
`endif
endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with WIDTH=5, DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_io_input_port;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    io_input_port_if #(.WIDTH(5)) bus ();

    io_input_port #(.WIDTH(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_irq(input string tag, input logic exp);
`ifdef IO_INPUT_IRQ_EN
        check(tag, {31'b0, bus.irq}, {31'b0, exp});
`endif
    endtask

    task automatic read_status();
        bus.rd_en = 1'b1;
        step(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.raw_in = 5'b00000;
        bus.rd_en  = 1'b0;
        step(2);
        reset = 1'b0;
        check("reset_in_port", bus.in_port, 32'h0);
        check("reset_status",  bus.status,  32'h0);
        check_irq("reset_irq", 1'b0);

        // Clean change: accepted on the 6th edge counted from the sampling edge
        bus.raw_in = 5'b10101;
        step(5);
        check("clean_pre_in_port", bus.in_port, 32'h0);
        check("clean_pre_status",  bus.status,  32'h0);
        check_irq("clean_pre_irq", 1'b0);
        step(1);
        check("clean_in_port", bus.in_port, 32'h15);
        check("clean_status",  bus.status,  32'h1);
        check_irq("clean_irq", 1'b1);
        read_status();
        check("clean_read_status",  bus.status,  32'h0);
        check("clean_read_in_port", bus.in_port, 32'h15);
        check_irq("clean_read_irq", 1'b0);

        // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse accepted
        reset = 1'b1;
        bus.raw_in = 5'b00000;
        step(1);
        reset = 1'b0;
        check("glitch_reset_in_port", bus.in_port, 32'h0);
        bus.raw_in = 5'b00001;
        step(3);
        bus.raw_in = 5'b00000;
        step(8);
        check("glitch3_in_port", bus.in_port, 32'h0);
        check("glitch3_status",  bus.status,  32'h0);
        bus.raw_in = 5'b00001;
        step(4);
        bus.raw_in = 5'b00000;
        step(2);
        check("pulse4_in_port", bus.in_port, 32'h1);
        check("pulse4_status",  bus.status,  32'h1);
        step(10);
        check("pulse4_return_in_port", bus.in_port, 32'h0);
        check("pulse4_return_status",  bus.status,  32'h3);
        read_status();
        check("pulse4_read_status", bus.status, 32'h0);

        // Overrun: two unread changes
        bus.raw_in = 5'b00011;
        step(6);
        check("ovr_first_in_port", bus.in_port, 32'h3);
        check("ovr_first_status",  bus.status,  32'h1);
        bus.raw_in = 5'b00111;
        step(6);
        check("ovr_second_in_port", bus.in_port, 32'h7);
        check("ovr_second_status",  bus.status,  32'h3);
        read_status();
        check("ovr_read_status", bus.status, 32'h0);

        // Simultaneous rd_en with the accepting edge while pending is set
        bus.raw_in = 5'b00001;
        step(6);
        check("simul_pending_status", bus.status, 32'h1);
        bus.raw_in = 5'b01111;
        step(5);
        bus.rd_en = 1'b1;
        step(1);
        bus.rd_en = 1'b0;
        check("simul_in_port", bus.in_port, 32'h0F);
        check("simul_status",  bus.status,  32'h1);
        check_irq("simul_irq", 1'b1);
        read_status();
        check("simul_read_status", bus.status, 32'h0);

        // Reset in the middle of a debounce discards the partial count
        bus.raw_in = 5'b11111;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_in_port", bus.in_port, 32'h0);
        check("midrst_status",  bus.status,  32'h0);
        check_irq("midrst_irq", 1'b0);
        step(5);
        check("midrst_pre_in_port", bus.in_port, 32'h0);
        step(1);
        check("midrst_in_port_after", bus.in_port, 32'h1F);
        check("midrst_status_after",  bus.status,  32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
